// File: rtl/flag_pkg.sv
// Shared defaults, FSM state type and thermometer helper for the flag serializer.
package flag_pkg;

    localparam int FLAG_NFLAGS = 10;
    localparam int FLAG_CODE_W = 5;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    function automatic logic thermo_bit(input int unsigned code, input int unsigned idx);
        return idx < code;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous code buffer; combinational head read, push ignored while full, pop ignored while empty.
module code_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_push;
    logic         w_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/flag_thermo_serializer.sv
// Expands buffered count codes into NFLAGS-bit thermometer frames streamed LSB first;
// first bit one cycle after the pop, outputs registered and held while out_ready is low.
module flag_thermo_serializer
    import flag_pkg::*;
#(
    parameter int NFLAGS     = FLAG_NFLAGS,
    parameter int CODE_W     = FLAG_CODE_W,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic              out_last,
    output logic              err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  frame_cnt
);
    localparam int                IW       = $clog2(NFLAGS);
    localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(NFLAGS);
    localparam logic [IW-1:0]     LAST_IDX = IW'(NFLAGS - 1);

    state_t            r_state;
    logic [CODE_W-1:0] r_code;
    logic [IW-1:0]     r_idx;
    logic              r_out_vld;
    logic              r_out_bit;
    logic              r_out_last;
    logic              r_err;
    logic [CNT_W-1:0]  r_frame_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_acc;
    logic              w_over;
    logic              w_pop;
    logic [CODE_W-1:0] w_sat_code;
    logic [CODE_W-1:0] w_head;
    logic [IW-1:0]     w_idx_nxt;

    assign in_ready   = !w_full;
    assign w_acc      = in_valid && in_ready;
    assign w_over     = (in_code > MAX_CODE);
    assign w_sat_code = w_over ? MAX_CODE : in_code;
    assign w_idx_nxt  = r_idx + IW'(1);
    // Head is consumed on the IDLE->EMIT step and on the last beat of each frame.
    assign w_pop      = (r_state == IDLE) || (out_ready && r_out_last);

    code_fifo #(
        .W     (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_code_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_acc),
        .pop   (w_pop),
        .din   (w_sat_code),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_acc && w_over) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_idx       <= '0;
            r_out_vld   <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state    <= EMIT;
                        r_code     <= w_head;
                        r_idx      <= '0;
                        r_out_vld  <= 1'b1;
                        r_out_bit  <= thermo_bit(32'(w_head), 0);
                        r_out_last <= (LAST_IDX == '0);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (!r_out_last) begin
                            r_idx      <= w_idx_nxt;
                            r_out_bit  <= thermo_bit(32'(r_code), 32'(w_idx_nxt));
                            r_out_last <= (w_idx_nxt == LAST_IDX);
                        end else begin
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            if (!w_empty) begin
                                r_code     <= w_head;
                                r_idx      <= '0;
                                r_out_bit  <= thermo_bit(32'(w_head), 0);
                                r_out_last <= (LAST_IDX == '0);
                            end else begin
                                r_state    <= IDLE;
                                r_out_vld  <= 1'b0;
                                r_out_bit  <= 1'b0;
                                r_out_last <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_vld;
    assign out_bit   = r_out_bit;
    assign out_last  = r_out_last;
    assign err       = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_flag_thermo_serializer.sv
// Scoreboard bench: stimulus queues expected {bit,last} beats, a negedge monitor checks transfers and stall holds.
module tb_flag_thermo_serializer;

    localparam int NFLAGS = 10;
    localparam int CODE_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic              out_last;
    logic              err;
    logic              err_clr;
    logic [CNT_W-1:0]  frame_cnt;

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int run      = 0;
    int last_run = 0;
    logic bp_en  = 1'b0;
    logic [1:0] exp_q[$];

    logic have_prev = 1'b0;
    logic prev_bit;
    logic prev_last;

    flag_thermo_serializer #(
        .NFLAGS     (NFLAGS),
        .CODE_W     (CODE_W),
        .FIFO_DEPTH (2),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .err       (err),
        .err_clr   (err_clr),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    // Expected frame: flag k is 1 when k < saturated code, last on flag NFLAGS-1.
    task automatic expect_frame(input int code);
        int sat;
        sat = (code > NFLAGS) ? NFLAGS : code;
        for (int k = 0; k < NFLAGS; k++)
            exp_q.push_back({(k < sat) ? 1'b1 : 1'b0, (k == NFLAGS-1) ? 1'b1 : 1'b0});
    endtask

    task automatic send(input int code);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_code  = CODE_W'(code);
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            timeout("send_accept");
        end else begin
            @(posedge clk); #1;
            expect_frame(code);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || out_valid) timeout("drain");
        @(negedge clk); #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            run       = 0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_bit !== prev_bit || out_last !== prev_last) begin
                    failures++;
                    $display("FAIL stall_hold got=%b%b%b expected=1%b%b",
                             out_valid, out_bit, out_last, prev_bit, prev_last);
                end
            end
            have_prev = out_valid && !out_ready;
            prev_bit  = out_bit;
            prev_last = out_last;
            if (out_valid && out_ready) begin
                logic [1:0] e;
                xfers++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got=%b%b expected=none", out_bit, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_bit, out_last} !== e) begin
                        failures++;
                        $display("FAIL beat got=%b%b expected=%b%b", out_bit, out_last, e[1], e[0]);
                    end
                end
            end
            if (out_valid) begin
                run++;
            end else if (run != 0) begin
                last_run = run;
                run      = 0;
            end
        end
    end

    initial begin
        int base;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = '0;
        err_clr  = 1'b0;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_bit",   32'(out_bit),   0);
        check("rst_out_last",  32'(out_last),  0);
        check("rst_err",       32'(err),       0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        rst_n = 1'b1;
        tick(1);
        check("rst_in_ready", 32'(in_ready), 1);

        send(3);
        drain();
        check("single_frame_cnt", 32'(frame_cnt), 1);

        send(0);
        drain();
        send(10);
        drain();
        check("code10_err", 32'(err), 0);
        send(31);
        drain();
        check("code31_err", 32'(err), 1);
        check("bound_frame_cnt", 32'(frame_cnt), 4);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("err_clr", 32'(err), 0);

        send(5);
        send(2);
        send(7);
        check("full_in_ready", 32'(in_ready), 0);
        drain();
        check("b2b_run_len", 32'(last_run), 30);
        check("b2b_frame_cnt", 32'(frame_cnt), 7);

        bp_en = 1'b1;
        send(4);
        drain();
        bp_en = 1'b0;
        tick(1);
        check("bp_frame_cnt", 32'(frame_cnt), 8);

        base = xfers;
        send(9);
        n = 0;
        while (xfers < base + 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (xfers < base + 4) timeout("mid_frame_wait");
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_bit",   32'(out_bit),   0);
        check("mid_rst_out_last",  32'(out_last),  0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check("mid_rst_in_ready",  32'(in_ready),  1);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        send(1);
        drain();
        check("post_rst_frame_cnt", 32'(frame_cnt), 1);

        for (int i = 0; i < 16; i++) send(i % 11);
        drain();
        check("wrap_frame_cnt", 32'(frame_cnt), 1);

        check("pre_coincide_err", 32'(err), 0);
        err_clr = 1'b1;
        send(20);
        err_clr = 1'b0;
        check("coincide_err", 32'(err), 1);
        drain();
        check("final_frame_cnt", 32'(frame_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
